// File: rtl/wb_grf_if.sv
// -----------------------------------------------------------------------------
// wb_grf_if
//   Bus between the MEM/WB pipeline register / decode stage and the writeback
//   + register-file block (wb_grf).
//
//   Signals
//     IR_W        32  instruction in writeback
//     ALUResult_W 32  ALU result / effective load address
//     pc4_W       32  PC+4 of the W instruction (trace only)
//     pc8_W       32  link value for jal
//     DM_RD_W     32  raw aligned word read from data memory
//     A1, A2       5  decode-stage read addresses
//     RD1, RD2    32  decode-stage read data
//     A3_W         5  effective destination (0 = no write)
//     WD_W        32  data being written this cycle
//
//   Modports
//     master : pipeline / decode side (drives W inputs and read addresses)
//     slave  : wb_grf
// -----------------------------------------------------------------------------
interface wb_grf_if;
  logic [31:0] IR_W;
  logic [31:0] ALUResult_W;
  logic [31:0] pc4_W;
  logic [31:0] pc8_W;
  logic [31:0] DM_RD_W;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [4:0]  A3_W;
  logic [31:0] WD_W;

  modport master (
    output IR_W, ALUResult_W, pc4_W, pc8_W, DM_RD_W, A1, A2,
    input  RD1, RD2, A3_W, WD_W
  );

  modport slave (
    input  IR_W, ALUResult_W, pc4_W, pc8_W, DM_RD_W, A1, A2,
    output RD1, RD2, A3_W, WD_W
  );
endinterface

// File: rtl/wb_grf.sv
// -----------------------------------------------------------------------------
// wb_grf
//   Writeback stage and 32x32 general register file of the five-stage MIPS
//   pipeline. Decodes the W instruction, selects/extends the write data,
//   commits it on the clock edge and serves the two decode read ports with
//   same-cycle write-through. A3_W/WD_W are exported for W-stage forwarding.
//
//   Ports
//     clk    pipeline clock, register writes on posedge
//     reset  asynchronous, active-low; clears every register
//     bus    wb_grf_if.slave (W inputs, read addresses/data, A3_W/WD_W)
//
//   Configuration
//     WB_GRF_TRACE_EN  when defined, prints one trace line per committed write
//                      "@<pc>: $<reg> <= <data>". Undefined: no display code.
// -----------------------------------------------------------------------------
module wb_grf (
  input  logic     clk,
  input  logic     reset,
  wb_grf_if.slave  bus
);

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LB      = 6'b100000;
  localparam logic [5:0] OP_LH      = 6'b100001;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_LBU     = 6'b100100;
  localparam logic [5:0] OP_LHU     = 6'b100101;

  // SPECIAL function codes
  localparam logic [5:0] FN_ADDU    = 6'b100001;
  localparam logic [5:0] FN_SUBU    = 6'b100011;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LINK,
    SRC_LOAD
  } wd_src_e;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [1:0]  byte_addr;

  wd_src_e     wd_src;
  logic [4:0]  dst;
  logic [4:0]  a3;
  logic [31:0] load_data;
  logic [31:0] wd;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  logic [31:0] regs [32];

  assign op        = bus.IR_W[31:26];
  assign rt        = bus.IR_W[20:16];
  assign rd        = bus.IR_W[15:11];
  assign funct     = bus.IR_W[5:0];
  assign byte_addr = bus.ALUResult_W[1:0];

  // ---------------------------------------------------------------------------
  // Decode: which instructions write, and where.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    wd_src = SRC_NONE;
    dst    = 5'd0;
    case (op)
      OP_SPECIAL: begin
        if (funct == FN_ADDU || funct == FN_SUBU) begin
          wd_src = SRC_ALU;
          dst    = rd;
        end
      end
      OP_ORI, OP_LUI: begin
        wd_src = SRC_ALU;
        dst    = rt;
      end
      OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: begin
        wd_src = SRC_LOAD;
        dst    = rt;
      end
      OP_JAL: begin
        wd_src = SRC_LINK;
        dst    = 5'd31;
      end
      default: ;
    endcase
  end

  // A destination of $0 naturally reports 0, which also discards the write.
  assign a3 = (wd_src == SRC_NONE) ? 5'd0 : dst;

  // ---------------------------------------------------------------------------
  // Load extension: little-endian lanes selected by the low address bits.
  // Halfword selection uses only bit 1; bit 0 is ignored.
  // ---------------------------------------------------------------------------
  always_comb begin
    case (byte_addr)
      2'd0:    load_byte = bus.DM_RD_W[7:0];
      2'd1:    load_byte = bus.DM_RD_W[15:8];
      2'd2:    load_byte = bus.DM_RD_W[23:16];
      default: load_byte = bus.DM_RD_W[31:24];
    endcase
  end

  assign load_half = byte_addr[1] ? bus.DM_RD_W[31:16] : bus.DM_RD_W[15:0];

  always_comb begin
    case (op)
      OP_LB:   load_data = {{24{load_byte[7]}}, load_byte};
      OP_LBU:  load_data = {24'd0, load_byte};
      OP_LH:   load_data = {{16{load_half[15]}}, load_half};
      OP_LHU:  load_data = {16'd0, load_half};
      default: load_data = bus.DM_RD_W;
    endcase
  end

  always_comb begin
    case (wd_src)
      SRC_ALU:  wd = bus.ALUResult_W;
      SRC_LINK: wd = bus.pc8_W;
      SRC_LOAD: wd = load_data;
      default:  wd = 32'd0;
    endcase
  end

  assign bus.A3_W = a3;
  assign bus.WD_W = wd;

  // ---------------------------------------------------------------------------
  // Register file. $0 is never written (a3 == 0 blocks it) and is masked on
  // read, so its storage stays at its reset value.
  // ---------------------------------------------------------------------------
  // NOTE: the whole array is cleared by the asynchronous reset because the
  // architecture requires every register to read 0 out of reset; this forces
  // flops rather than a RAM macro, which is intended for a 32x32 file.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (a3 != 5'd0) begin
      regs[a3] <= wd;
    end
  end

  // Read ports with zero-cycle write-through from the W stage.
  assign bus.RD1 = (bus.A1 == 5'd0) ? 32'd0 :
                   (bus.A1 == a3)   ? wd    : regs[bus.A1];
  assign bus.RD2 = (bus.A2 == 5'd0) ? 32'd0 :
                   (bus.A2 == a3)   ? wd    : regs[bus.A2];

  // Instruction fields that do not affect writeback.
  logic unused_ir;
  assign unused_ir = ^{bus.IR_W[25:21], bus.IR_W[10:6]};

`ifdef WB_GRF_TRACE_EN
  always @(posedge clk) begin
    if (reset && a3 != 5'd0) begin
      $display("@%h: $%d <= %h", bus.pc4_W - 32'd4, a3, wd);
    end
  end
`else
  // PC is only consumed by the trace.
  logic unused_pc4;
  assign unused_pc4 = ^bus.pc4_W;
`endif

endmodule

// File: doc/wb_grf.md
# wb_grf

Writeback stage and general register file for the five-stage MIPS pipeline. It consumes the MEM/WB pipeline register contents (instruction, ALU result, PC+4/PC+8, raw memory read word) and decodes the writeback instruction. It selects and extends the write data, commits it to the 32×32 register file on the clock edge, and serves the two decode-stage read ports with same-cycle write-through. It also exports the committed destination/data so the hazard unit can forward from W.

## Interface
- No parameters; register count (32) and width (32) are fixed by the ISA.
- `clk` input 1: pipeline clock; all register writes on posedge.
- `reset` input 1: asynchronous, active-low; clears every register.
- `IR_W` input 32: instruction in writeback stage.
- `ALUResult_W` input 32: ALU result / effective load address.
- `pc4_W` input 32: PC+4 of the W instruction; used for trace only.
- `pc8_W` input 32: link value for `jal`.
- `DM_RD_W` input 32: raw aligned word read from data memory.
- `A1` input 5: decode read address 1 (rs).
- `A2` input 5: decode read address 2 (rt).
- `RD1` output 32: read data for `A1`.
- `RD2` output 32: read data for `A2`.
- `A3_W` output 5: effective destination; 0 when the W instruction does not write.
- `WD_W` output 32: data being written this cycle; valid when `A3_W != 0`.

## Operation
- Decode: `op = IR_W[31:26]`, `funct = IR_W[5:0]`.
- Writers and destinations:
  - `addu`/`subu` (op 0, funct 100001/100011): `rd`.
  - `ori` (001101) and `lui` (001111): `rt`.
  - `lw` 100011, `lb` 100000, `lbu` 100100, `lh` 100001, `lhu` 100101: `rt`.
  - `jal` (000011): 31.
- All other encodings write nothing, including `sw`, `beq`, `j`, `jr`, `nop`/all-zero and undefined opcodes; these force `A3_W = 0`.
- Write data:
  - ALU-class instructions: `ALUResult_W`.
  - `jal`: `pc8_W`.
  - Loads: extended from `DM_RD_W`.
- Load extension (little-endian lanes, `a = ALUResult_W[1:0]`):
  - `lw`: whole word.
  - `lb`/`lbu`: byte `DM_RD_W[8a+7:8a]`, sign-/zero-extended.
  - `lh`/`lhu`: half selected by `a[1]`, sign-/zero-extended; `a[0]` ignored.
- `$0` always reads 0; a write to `$0` is discarded, so `A3_W` reports 0.
- Read ports:
  - `RDn = 0` if `An == 0`.
  - Else `RDn = WD_W` if `An == A3_W`.
  - Else the stored register value.

## Timing
- Register write takes effect at the posedge following the cycle in which `IR_W` is presented; `IR_W` is stable for one cycle per instruction.
- `A3_W`/`WD_W` are combinational from the W inputs, valid in that same cycle.
- `RD1`/`RD2` are combinational with zero-cycle write-through; a W write and a D read of the same register in one cycle return the new value.
- Reset:
  - `reset` low clears `$1..$31` to 0 immediately, independent of `clk`.
  - A posedge while `reset` is low performs no write.
  - Deassertion is effective at the next posedge.
- Reset mid-write: an edge coinciding with `reset` low is dropped, and the register stays 0.
- Both read ports addressing the destination in the same cycle both return `WD_W`.

## Configuration
- `WB_GRF_TRACE_EN` defined:
  - On every committing posedge (reset high, `A3_W != 0`), `$display("@%h: $%d <= %h", pc4_W - 4, A3_W, WD_W)`.
  - Writes to `$0` are not printed.
- Undefined: no display statements are compiled, and functional behaviour is identical.

## Test plan
- Reset and `$0`:
  - Drive `reset` low mid-cycle after loading `$5 = 0x1234` → `$5` reads 0 immediately with no clock.
  - `addu` with `rd = 0` and `ALUResult_W = 0xFFFF` → `RD1(A1 = 0) = 0` and `A3_W = 0`.
- `jal`: `IR_W = 0x0C000010`, `pc8_W = 0x3008` → after the edge `$31 = 0x00003008`; trace prints pc `0x3000` (with `pc4_W = 0x3004`).
- Loads with `DM_RD_W = 0x80FF7F01`:
  - `lb`, a = 1 → `0x0000007F`.
  - `lb`, a = 3 → `0xFFFFFF80`.
  - `lbu`, a = 2 → `0x000000FF`.
  - `lh`, a = 2 → `0xFFFF80FF`.
  - `lhu`, a = 0 → `0x00007F01`.
- Write-through: `ori` writing `$8 = 0xABCD` with `A1 = A2 = 8` in the same cycle → `RD1 = RD2 = 0xABCD` before the edge; the value persists after the edge.
- Non-writers: `sw`, `beq`, `jr`, and `IR_W = 0` each with `ALUResult_W = 0xDEAD` → `A3_W = 0`, all registers unchanged, no trace line.
